// File: rtl/ram_stream_reader.sv
// Streams a contiguous block of words out of a simple dual-port RAM read port.
// Each RAM read returns its word one cycle later, and a 2-entry skid FIFO carries the words onto a valid/ready stream.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rddata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  pending;
  logic                  pending_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic                  done_q;

  logic push, pop, credit_ok, issue, drain_ok, flush;

  // Stream handshake: a word transfers in any cycle where out_valid and out_ready
  // are both high. out_valid never depends on out_ready, and the word holds while stalled.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = pending;
    credit_ok = (fifo_count == 2'd0) || (fifo_count == 2'd1 && !pending);
    issue     = (state == S_ISSUE) && (credit_ok || pop);
    drain_ok  = !pending && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));
    flush     = abort && (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_IDLE;
      rd_addr      <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state        <= S_IDLE;
        pending      <= 1'b0;
        pending_last <= 1'b0;
        wr_ptr       <= 1'b0;
        rd_ptr       <= 1'b0;
        fifo_count   <= 2'd0;
      end else begin
        pending      <= issue;
        pending_last <= issue && (remaining == LEN_WIDTH'(1));
        if (push) begin
          fifo_last[wr_ptr] <= pending_last;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        if (push && !pop)      fifo_count <= fifo_count + 2'd1;
        else if (pop && !push) fifo_count <= fifo_count - 2'd1;

        case (state)
          S_IDLE: begin
            if (start) begin
              rd_addr   <= start_addr;
              remaining <= start_len;
              state     <= (start_len == '0) ? S_DRAIN : S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (issue) begin
              rd_addr   <= rd_addr + ADDR_WIDTH'(1);
              remaining <= remaining - LEN_WIDTH'(1);
              if (remaining == LEN_WIDTH'(1)) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (drain_ok) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by fifo_count.
  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= ram_rddata;
  end

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign ram_addr  = rd_addr;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid && fifo_last[rd_ptr];
  assign dbg_state = state;

endmodule
